sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of SRAM-like master channels (2..8); channel 0 is the instruction side, channel 1 the data side.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width (multiple of 8).
REQ-004 Parameter OT_DEPTH, default 4, maximum outstanding transactions (power of 2, >= 2).
REQ-005 Parameter ARB_MODE, default 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 Ports: one per line, listed as name, direction, width, meaning.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag (1 = write).
- m_size  in  2*NUM_CH  per-channel size code (0 = byte, 1 = half, 2 = word).
- m_addr  in  AW*NUM_CH  per-channel address.
- m_wstrb  in  (DW/8)*NUM_CH  per-channel byte strobes.
- m_wdata  in  DW*NUM_CH  per-channel write data.
- m_addr_ok  out  NUM_CH  per-channel request accepted.
- m_data_ok  out  NUM_CH  per-channel response returned.
- m_rdata  out  DW  shared read data, valid for the channel whose m_data_ok is high.
- s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/1/2/AW/DW/8/DW  slave request fields.
- s_addr_ok, s_data_ok  in  1  slave handshakes.
- s_rdata  in  DW  slave read data.
- ot_cnt  out  log2(OT_DEPTH)+1  outstanding transaction count.

Function
REQ-007 Request handshake: a transfer completes on a cycle with s_req && s_addr_ok; m_addr_ok[g] = that condition for the granted channel g and is 0 for all other channels.
REQ-008 s_req = m_req[g] && !fifo_full && !reset; all slave request fields mux combinationally from channel g.
REQ-009 Unlocked grant: fixed mode picks the lowest-index requesting channel; round-robin picks the first requesting channel at or after rr_ptr, with wrap from NUM_CH-1 to 0.
REQ-010 Lock: if s_req is high and s_addr_ok is low, then g is registered and held, and the slave fields stay stable, until the handshake completes; new higher-priority requests do not preempt.
REQ-011 Round-robin: on each completed handshake, rr_ptr <= (g+1) mod NUM_CH; rr_ptr is unused in fixed mode.
REQ-012 Order FIFO: each handshake pushes g into a FIFO of OT_DEPTH entries; fifo_full is asserted when ot_cnt == OT_DEPTH, and then no s_req is issued.
REQ-013 Responses: responses return in order. On s_data_ok with the FIFO non-empty:
- m_data_ok[head] = 1;
- m_rdata = s_rdata;
- the head is popped.
REQ-014 s_data_ok with the FIFO empty is ignored: no m_data_ok and no state change.
REQ-015 Simultaneous push and pop in one cycle leaves ot_cnt unchanged, and both pointers advance mod OT_DEPTH.
REQ-016 A response never belongs to a request accepted in the same cycle; zero-latency slaves are not supported.
REQ-017 A pop when full frees an entry; a new push is allowed from the next cycle (s_req depends on the registered count).
REQ-018 Latency: the arbiter adds zero cycles on both the request and response paths (purely combinational forwarding, registered bookkeeping only).

Reset
REQ-019 While reset = 1, the following state and outputs are forced:
- FIFO empty, ot_cnt = 0, rr_ptr = 0, lock cleared;
- s_req = 0, m_addr_ok = 0, m_data_ok = 0.
REQ-020 Reset mid-operation discards all outstanding entries; slave responses arriving after reset deassertion, with the FIFO empty, are ignored per REQ-014.

Verification
REQ-021 Fixed mode, NUM_CH = 2:
- Stimulus: m_req = 2'b11 with s_addr_ok = 1 every cycle.
- Required response: channel 0 is granted every cycle and channel 1 is starved; ot_cnt saturates at 4 and s_req drops to 0.
REQ-022 Round-robin mode, NUM_CH = 3:
- Stimulus: all channels request, s_addr_ok = 1, and s_data_ok = 1 one cycle after each request.
- Required response: the grant sequence is 0, 1, 2, 0; m_data_ok follows the same order, one cycle later.
REQ-023 Lock:
- Stimulus: channel 1 is granted with s_addr_ok = 0 for 3 cycles, then channel 0 raises m_req.
- Required response: s_addr stays equal to channel 1's address until s_addr_ok, and channel 0 is granted on the following cycle.
REQ-024 Full and simultaneous:
- Stimulus: with ot_cnt = 4, a cycle with s_data_ok = 1.
- Required response: ot_cnt becomes 3 and s_req reasserts the next cycle. A later cycle with both a push and a pop holds ot_cnt at 3.
REQ-025 Spurious response and reset:
- Stimulus: s_data_ok while the FIFO is empty.
- Required response: no m_data_ok.
- Stimulus: assert reset with ot_cnt = 2.
- Required response: ot_cnt = 0 and all outputs are 0 on the next edge.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// Bundle of channel-side and SRAM-side signals for sram_req_arbiter.
// The "slave" modport is the arbiter's view. It serves the channel masters
// and forwards their requests to the SRAM. The "master" modport is the
// environment's view, which drives the channels and the SRAM responses.
interface sram_req_arbiter_if #(
    parameter int NUM_CH   = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int OT_DEPTH = 4
);
    localparam int CNT_W = $clog2(OT_DEPTH) + 1;

    logic [NUM_CH-1:0]        m_req;
    logic [NUM_CH-1:0]        m_wr;
    logic [2*NUM_CH-1:0]      m_size;
    logic [AW*NUM_CH-1:0]     m_addr;
    logic [(DW/8)*NUM_CH-1:0] m_wstrb;
    logic [DW*NUM_CH-1:0]     m_wdata;
    logic [NUM_CH-1:0]        m_addr_ok;
    logic [NUM_CH-1:0]        m_data_ok;
    logic [DW-1:0]            m_rdata;

    logic                     s_req;
    logic                     s_wr;
    logic [1:0]               s_size;
    logic [AW-1:0]            s_addr;
    logic [DW/8-1:0]          s_wstrb;
    logic [DW-1:0]            s_wdata;
    logic                     s_addr_ok;
    logic                     s_data_ok;
    logic [DW-1:0]            s_rdata;

    logic [CNT_W-1:0]         ot_cnt;

    modport slave (
        input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        output ot_cnt
    );

    modport master (
        output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        input  ot_cnt
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// N-to-1 arbiter for SRAM-like request/response channels.
// Requests and responses are forwarded combinationally. The arbiter keeps
// registered bookkeeping only: a grant lock for stalled requests, the
// round-robin pointer, and an in-order FIFO that records which channel
// owns each outstanding response.
module sram_req_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int OT_DEPTH = 4,
    parameter int ARB_MODE = 0
) (
    input logic               clk,
    input logic               reset,
    sram_req_arbiter_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(OT_DEPTH);
    localparam int SW = DW / 8;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(OT_DEPTH);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t     state, state_nxt;
    logic [CW-1:0]   lock_ch, lock_ch_nxt;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   free_grant;
    logic [CW-1:0]   grant;
    logic [NUM_CH-1:0] hi_mask;
    logic [NUM_CH-1:0] req_hi;

    logic [CW-1:0]   order_fifo [OT_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     ot_cnt_q;
    logic [CW-1:0]   head_ch;
    logic            fifo_full, fifo_empty;
    logic            handshake, pop;

    assign fifo_full  = (ot_cnt_q == FULL_CNT);
    assign fifo_empty = (ot_cnt_q == '0);
    assign head_ch    = order_fifo[rd_ptr];

    // Unlocked choice: lowest requester, or in round-robin the lowest requester at or above rr_ptr, falling back to the lowest overall (wrap).
    always_comb begin
        free_grant = '0;
        hi_mask    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi_mask[i] = (CW'(i) >= rr_ptr);
        end
        req_hi = bus.m_req & hi_mask;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.m_req[i]) free_grant = CW'(i);
        end
        if (ARB_MODE == 1 && (|req_hi)) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req_hi[i]) free_grant = CW'(i);
            end
        end
    end

    assign grant = (state == ST_LOCKED) ? lock_ch : free_grant;

    // Slave request path is a pure mux of the granted channel.
    assign bus.s_req   = bus.m_req[grant] && !fifo_full && !reset;
    assign bus.s_wr    = bus.m_wr[grant];
    assign bus.s_size  = bus.m_size[grant*2 +: 2];
    assign bus.s_addr  = bus.m_addr[grant*AW +: AW];
    assign bus.s_wstrb = bus.m_wstrb[grant*SW +: SW];
    assign bus.s_wdata = bus.m_wdata[grant*DW +: DW];

    assign handshake = bus.s_req && bus.s_addr_ok;
    assign pop       = bus.s_data_ok && !fifo_empty && !reset;

    assign bus.m_rdata = bus.s_rdata;
    assign bus.ot_cnt  = ot_cnt_q;

    // Per-channel acknowledges: address ack to the granted channel, data ack to the FIFO head owner.
    always_comb begin
        bus.m_addr_ok = '0;
        bus.m_data_ok = '0;
        if (handshake) bus.m_addr_ok[grant] = 1'b1;
        if (pop)       bus.m_data_ok[head_ch] = 1'b1;
    end

    // A stalled request pins the grant so the slave sees stable fields until it accepts.
    always_comb begin
        state_nxt   = ST_OPEN;
        lock_ch_nxt = lock_ch;
        if (bus.s_req && !bus.s_addr_ok) begin
            state_nxt   = ST_LOCKED;
            lock_ch_nxt = grant;
        end
    end

    // Lock, round-robin pointer and FIFO pointer/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OPEN;
            lock_ch  <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ot_cnt_q <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            if (handshake) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (ARB_MODE == 1) begin
                    rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
                end
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({handshake, pop})
                2'b10:   ot_cnt_q <= ot_cnt_q + 1'b1;
                2'b01:   ot_cnt_q <= ot_cnt_q - 1'b1;
                default: ot_cnt_q <= ot_cnt_q;
            endcase
        end
    end

    // Order FIFO storage; entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (handshake) order_fifo[wr_ptr] <= grant;
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter. Two instances are used: A is fixed priority
// with 2 channels, and B is round-robin with 3 channels. A queue-style
// reference model is checked every cycle. Directed sequences add literal
// expectations on top of the model.
module tb_sram_req_arbiter;
    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter_if #(.NUM_CH(2), .AW(32), .DW(32), .OT_DEPTH(4)) if_a ();
    sram_req_arbiter_if #(.NUM_CH(3), .AW(32), .DW(32), .OT_DEPTH(4)) if_b ();

    sram_req_arbiter #(.NUM_CH(2), .AW(32), .DW(32), .OT_DEPTH(4), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset(reset_a), .bus(if_a));
    sram_req_arbiter #(.NUM_CH(3), .AW(32), .DW(32), .OT_DEPTH(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset(reset_b), .bus(if_b));

    localparam logic [31:0] A_ADDR0 = 32'h0000_1000;
    localparam logic [31:0] A_ADDR1 = 32'h0000_2004;

    // Reference model state per instance: outstanding owners as a ring, rr pointer, lock.
    int mdl_cnt [2];
    int mdl_head [2];
    int mdl_rr [2];
    int mdl_lock [2];
    int mdl_lock_ch [2];
    int mdl_fifo [2][4];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // One cycle of the model: derive expected outputs from the rules, compare, then commit state.
    task automatic modelCycle(input int d, input int nch, input int mode, input logic rst,
                              input logic [7:0] req, input logic saok, input logic sdok,
                              input logic [31:0] rdata, input logic [255:0] addr_flat,
                              input logic act_sreq, input logic [7:0] act_aok,
                              input logic [7:0] act_dok, input logic [31:0] act_rdata,
                              input logic [31:0] act_saddr, input logic [3:0] act_cnt);
        string      p;
        int         g;
        int         c;
        int         tail;
        logic       exp_sreq;
        logic [7:0] exp_aok;
        logic [7:0] exp_dok;
        p = (d == 0) ? "A" : "B";
        g = 0;
        exp_sreq = 1'b0;
        exp_aok  = '0;
        exp_dok  = '0;
        checkOutput({p, ".ot_cnt"}, 64'(act_cnt), 64'(mdl_cnt[d]));
        if (!rst) begin
            if (mdl_lock[d] != 0) begin
                g = mdl_lock_ch[d];
            end else begin
                g = -1;
                for (int k = 0; k < nch; k++) begin
                    c = (mode == 1) ? (mdl_rr[d] + k) % nch : k;
                    if (g < 0 && req[c]) g = c;
                end
                if (g < 0) g = 0;
            end
            exp_sreq = req[g] && (mdl_cnt[d] < 4);
            exp_aok  = (exp_sreq && saok) ? 8'(1 << g) : 8'h00;
            exp_dok  = (sdok && mdl_cnt[d] > 0) ? 8'(1 << mdl_fifo[d][mdl_head[d]]) : 8'h00;
        end
        checkOutput({p, ".s_req"}, 64'(act_sreq), 64'(exp_sreq));
        checkOutput({p, ".m_addr_ok"}, 64'(act_aok), 64'(exp_aok));
        checkOutput({p, ".m_data_ok"}, 64'(act_dok), 64'(exp_dok));
        if (exp_sreq) checkOutput({p, ".s_addr"}, 64'(act_saddr), 64'(addr_flat[g*32 +: 32]));
        if (exp_dok != 0) checkOutput({p, ".m_rdata"}, 64'(act_rdata), 64'(rdata));
        if (rst) begin
            mdl_cnt[d] = 0; mdl_head[d] = 0; mdl_rr[d] = 0;
            mdl_lock[d] = 0; mdl_lock_ch[d] = 0;
        end else begin
            tail = (mdl_head[d] + mdl_cnt[d]) % 4;
            if (exp_aok != 0) begin
                mdl_fifo[d][tail] = g;
                mdl_cnt[d]++;
                if (mode == 1) mdl_rr[d] = (g + 1) % nch;
            end
            if (exp_dok != 0) begin
                mdl_head[d] = (mdl_head[d] + 1) % 4;
                mdl_cnt[d]--;
            end
            mdl_lock[d]    = (exp_sreq && !saok) ? 1 : 0;
            mdl_lock_ch[d] = g;
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        modelCycle(0, 2, 0, reset_a, {6'b0, if_a.m_req}, if_a.s_addr_ok, if_a.s_data_ok,
                   if_a.s_rdata, {192'b0, if_a.m_addr}, if_a.s_req, {6'b0, if_a.m_addr_ok},
                   {6'b0, if_a.m_data_ok}, if_a.m_rdata, if_a.s_addr, {1'b0, if_a.ot_cnt});
        modelCycle(1, 3, 1, reset_b, {5'b0, if_b.m_req}, if_b.s_addr_ok, if_b.s_data_ok,
                   if_b.s_rdata, {160'b0, if_b.m_addr}, if_b.s_req, {5'b0, if_b.m_addr_ok},
                   {5'b0, if_b.m_data_ok}, if_b.m_rdata, if_b.s_addr, {1'b0, if_b.ot_cnt});
    end

    task automatic applyStimulus(input int d, input logic rst, input logic [2:0] req,
                                 input logic saok, input logic sdok);
        if (d == 0) begin
            reset_a        = rst;
            if_a.m_req     = req[1:0];
            if_a.s_addr_ok = saok;
            if_a.s_data_ok = sdok;
            if_a.s_rdata   = $urandom;
        end else begin
            reset_b        = rst;
            if_b.m_req     = req;
            if_b.s_addr_ok = saok;
            if_b.s_data_ok = sdok;
            if_b.s_rdata   = $urandom;
        end
    endtask

    // Drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input int d, input logic rst, input logic [2:0] req,
                       input logic saok, input logic sdok);
        @(posedge clk);
        #1;
        applyStimulus(d, rst, req, saok, sdok);
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mdl_cnt[d] = 0; mdl_head[d] = 0; mdl_rr[d] = 0;
            mdl_lock[d] = 0; mdl_lock_ch[d] = 0;
            for (int e = 0; e < 4; e++) mdl_fifo[d][e] = 0;
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        if_a.m_req = '0; if_a.s_addr_ok = 1'b0; if_a.s_data_ok = 1'b0; if_a.s_rdata = '0;
        if_b.m_req = '0; if_b.s_addr_ok = 1'b0; if_b.s_data_ok = 1'b0; if_b.s_rdata = '0;
        if_a.m_addr  = {A_ADDR1, A_ADDR0};
        if_a.m_wr    = 2'b10;
        if_a.m_size  = 4'b10_01;
        if_a.m_wstrb = 8'hF3;
        if_a.m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        if_b.m_addr  = {32'h0000_5000, 32'h0000_4000, 32'h0000_3000};
        if_b.m_wr    = 3'b010;
        if_b.m_size  = 6'b10_01_00;
        if_b.m_wstrb = 12'hF31;
        if_b.m_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

        cyc(0, 1'b1, 3'b000, 1'b0, 1'b0);
        cyc(0, 1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("A.reset_ot_cnt", 64'(if_a.ot_cnt), 64'd0);
        checkOutput("A.reset_s_req", 64'(if_a.s_req), 64'd0);
        applyStimulus(1, 1'b0, 3'b000, 1'b0, 1'b0);

        // Fixed priority saturation: channel 0 always wins, FIFO fills to 4.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b0, 3'b011, 1'b1, 1'b0);
            checkOutput("A.fixed_grant", 64'(if_a.m_addr_ok), 64'b01);
            checkOutput("A.fill_cnt", 64'(if_a.ot_cnt), 64'(i));
        end
        cyc(0, 1'b0, 3'b011, 1'b1, 1'b0);
        checkOutput("A.full_s_req", 64'(if_a.s_req), 64'd0);
        checkOutput("A.full_cnt", 64'(if_a.ot_cnt), 64'd4);
        checkOutput("A.ch1_starved", 64'(if_a.m_addr_ok), 64'd0);

        // Pop while full, then push and pop together.
        cyc(0, 1'b0, 3'b011, 1'b1, 1'b1);
        checkOutput("A.full_pop_dok", 64'(if_a.m_data_ok), 64'b01);
        cyc(0, 1'b0, 3'b011, 1'b1, 1'b1);
        checkOutput("A.refill_cnt", 64'(if_a.ot_cnt), 64'd3);
        checkOutput("A.refill_s_req", 64'(if_a.s_req), 64'd1);
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("A.pushpop_cnt", 64'(if_a.ot_cnt), 64'd3);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 3'b000, 1'b0, 1'b1);

        // Lock: channel 1 stalls, channel 0 joins, channel 1 must finish first.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 3'b010, 1'b0, 1'b0);
            checkOutput("A.lock_addr", 64'(if_a.s_addr), 64'(A_ADDR1));
        end
        cyc(0, 1'b0, 3'b011, 1'b0, 1'b0);
        checkOutput("A.lock_hold_addr", 64'(if_a.s_addr), 64'(A_ADDR1));
        cyc(0, 1'b0, 3'b011, 1'b1, 1'b0);
        checkOutput("A.lock_release", 64'(if_a.m_addr_ok), 64'b10);
        cyc(0, 1'b0, 3'b011, 1'b1, 1'b0);
        checkOutput("A.after_lock_grant", 64'(if_a.m_addr_ok), 64'b01);
        checkOutput("A.after_lock_addr", 64'(if_a.s_addr), 64'(A_ADDR0));
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("A.inorder_first", 64'(if_a.m_data_ok), 64'b10);
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("A.inorder_second", 64'(if_a.m_data_ok), 64'b01);
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("A.spurious_dok", 64'(if_a.m_data_ok), 64'd0);

        // Reset with two outstanding entries.
        cyc(0, 1'b0, 3'b001, 1'b1, 1'b0);
        cyc(0, 1'b0, 3'b001, 1'b1, 1'b0);
        cyc(0, 1'b1, 3'b001, 1'b1, 1'b1);
        checkOutput("A.rst_cnt_before", 64'(if_a.ot_cnt), 64'd2);
        checkOutput("A.rst_s_req", 64'(if_a.s_req), 64'd0);
        cyc(0, 1'b1, 3'b001, 1'b1, 1'b1);
        checkOutput("A.rst_cnt_after", 64'(if_a.ot_cnt), 64'd0);
        checkOutput("A.rst_dok", 64'(if_a.m_data_ok), 64'd0);
        checkOutput("A.rst_aok", 64'(if_a.m_addr_ok), 64'd0);
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("A.post_rst_dok", 64'(if_a.m_data_ok), 64'd0);
        cyc(0, 1'b0, 3'b000, 1'b0, 1'b0);

        // Round-robin over three channels with responses one cycle behind.
        cyc(1, 1'b0, 3'b111, 1'b1, 1'b0);
        checkOutput("B.rr_grant0", 64'(if_b.m_addr_ok), 64'b001);
        cyc(1, 1'b0, 3'b111, 1'b1, 1'b1);
        checkOutput("B.rr_grant1", 64'(if_b.m_addr_ok), 64'b010);
        checkOutput("B.rr_resp0", 64'(if_b.m_data_ok), 64'b001);
        cyc(1, 1'b0, 3'b111, 1'b1, 1'b1);
        checkOutput("B.rr_grant2", 64'(if_b.m_addr_ok), 64'b100);
        checkOutput("B.rr_resp1", 64'(if_b.m_data_ok), 64'b010);
        cyc(1, 1'b0, 3'b111, 1'b1, 1'b1);
        checkOutput("B.rr_grant3", 64'(if_b.m_addr_ok), 64'b001);
        checkOutput("B.rr_resp2", 64'(if_b.m_data_ok), 64'b100);
        cyc(1, 1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("B.rr_resp3", 64'(if_b.m_data_ok), 64'b001);
        checkOutput("B.rr_cnt", 64'(if_b.ot_cnt), 64'd1);
        cyc(1, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("B.rr_drained", 64'(if_b.ot_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
